// File: rtl/num_encoder10.sv
// Debounced 10-key to BCD encoder: 2-flop sync, press/release debounce FSM, registered outputs.
// Latency DEB_CYCLES+3 edges from stable key to strobe; no flow control (level/pulse outputs).
module num_encoder10 #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_n,
    input  logic       LE,
    output logic [3:0] D,
    output logic       valid,
    output logic       strobe,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_REL_END = CNT_W'(DEB_CYCLES - 2);

    logic [9:0]       sync1;
    logic [9:0]       kv;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       cand_q, cand_d;
    logic             accept;

    function automatic logic [3:0] msb_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            kv    <= '0;
        end else begin
            sync1 <= ~key_n;
            kv    <= sync1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (kv != '0) begin
                    state_d = DEB;
                    cand_d  = kv;
                    cnt_d   = '0;
                end
            end
            DEB: begin
                if (kv == '0) begin
                    state_d = IDLE;
                end else if (kv != cand_q) begin
                    cand_d = kv;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (kv == '0) begin
                    state_d = REL;
                    cnt_d   = '0;
                end
            end
            REL: begin
                if (kv != '0) begin
                    state_d = HELD;
                end else begin
                    // the HELD sample counts as the first zero, so REL ends one count early
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_REL_END) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            D       <= 4'b1111;
            err     <= 1'b0;
            valid   <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            valid   <= (state_d == HELD) || (state_d == REL);
            strobe  <= accept && !LE;
            if (accept && !LE) begin
                D   <= msb_index(cand_q);
                err <= ($countones(cand_q) > 1);
            end
        end
    end
endmodule

// File: tb/tb_num_encoder10.sv
// Random + directed stimulus against a run-length reference model; per-cycle scoreboard.
module tb_num_encoder10;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] key_n = '1;
    logic       LE = 1'b0;
    logic [3:0] D;
    logic       valid, strobe, err;

    num_encoder10 #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .LE(LE),
        .D(D), .valid(valid), .strobe(strobe), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       s;
        logic       e;
        logic [3:0] d;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         done = 0;

    // reference model: raw samples, run lengths, held flag
    logic [9:0] samp[$];
    logic [9:0] last_kv;
    int         run, zrun;
    bit         held;
    exp_t       m;
    bit         in_reset = 1;

    function automatic int top_key(input logic [9:0] v);
        int r = 0;
        for (int i = 0; i < 10; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int nkeys(input logic [9:0] v);
        int c = 0;
        for (int i = 0; i < 10; i++) if (v[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        samp.delete();
        last_kv = '0;
        run = 0; zrun = 0; held = 0;
        m = '{v: 1'b0, s: 1'b0, e: 1'b0, d: 4'b1111};
    endtask

    task automatic model_edge(input logic [9:0] raw, input logic le);
        logic [9:0] kv;
        kv = (samp.size() >= 2) ? samp[samp.size()-2] : 10'd0;
        samp.push_back(raw);
        if (samp.size() > 4) void'(samp.pop_front());
        m.s = 1'b0;
        if (!held) begin
            if (kv == 0) run = 0;
            else if (kv == last_kv && run > 0) run++;
            else run = 1;
            last_kv = kv;
            if (run == DEB + 1) begin
                held = 1; zrun = 0;
                if (!le) begin
                    m.s = 1'b1;
                    m.d = 4'(top_key(kv));
                    m.e = (nkeys(kv) > 1);
                end
            end
        end else begin
            if (kv != 0) zrun = 0;
            else zrun++;
            if (zrun == DEB) begin
                held = 0; run = 0; last_kv = '0;
            end
        end
        m.v = held;
    endtask

    // one clock of stimulus: drive at negedge, predict the following posedge
    task automatic cyc(input logic [9:0] keys, input logic le, input logic rst);
        @(negedge clk);
        key_n = ~keys;
        LE    = le;
        rst_n = rst;
        if (!rst) begin
            model_reset();
            if (!in_reset) begin
                #1;
                vectors++;
                if ({valid, strobe, err, D} !== {m.v, m.s, m.e, m.d}) begin
                    miscompares++;
                    $display("FAIL async_reset: got v=%b s=%b e=%b D=%h, want v=0 s=0 e=0 D=f",
                             valid, strobe, err, D);
                end
            end
            in_reset = 1;
        end else begin
            in_reset = 0;
            model_edge(keys, le);
        end
        sb.push_back(m);
    endtask

    task automatic hold(input logic [9:0] keys, input logic le, input int n);
        for (int i = 0; i < n; i++) cyc(keys, le, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({valid, strobe, err, D} !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got v=%b s=%b e=%b D=%h, want v=%b s=%b e=%b D=%h",
                             $time, valid, strobe, err, D, e.v, e.s, e.e, e.d);
                end
            end
        end
    end

    initial begin : driver
        logic [9:0] k;
        int         len;
        model_reset();
        hold('0, 1'b0, 0);
        for (int i = 0; i < 3; i++) cyc('0, 1'b0, 1'b0);
        hold('0, 1'b0, 3);

        hold(10'(1 << 7), 1'b0, 12);        // single press
        hold('0, 1'b0, 8);

        for (int i = 0; i < 5; i++) begin   // bounce on key 3
            hold(10'(1 << 3), 1'b0, 2);
            hold('0, 1'b0, 2);
        end
        hold(10'(1 << 3), 1'b0, 12);
        hold('0, 1'b0, 8);

        hold(10'((1 << 2) | (1 << 9)), 1'b0, 12);  // two keys together
        hold('0, 1'b0, 8);

        hold(10'(1 << 5), 1'b0, 10);        // release glitches
        hold('0, 1'b0, 2);
        hold(10'(1 << 5), 1'b0, 6);
        hold('0, 1'b0, 3);
        hold(10'(1 << 5), 1'b0, 4);
        hold('0, 1'b0, 8);

        hold(10'(1 << 1), 1'b0, 12);        // latch enable freeze
        hold('0, 1'b0, 8);
        hold(10'(1 << 8), 1'b1, 12);
        hold('0, 1'b1, 8);

        hold(10'(1 << 6), 1'b0, 4);         // reset mid-debounce, key still held
        cyc(10'(1 << 6), 1'b0, 1'b0);
        cyc(10'(1 << 6), 1'b0, 1'b0);
        hold(10'(1 << 6), 1'b0, 12);
        cyc(10'(1 << 6), 1'b0, 1'b0);       // reset mid-hold
        hold(10'(1 << 6), 1'b0, 10);
        hold('0, 1'b0, 8);

        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 3))
                0: k = '0;
                1, 2: k = 10'(1 << $urandom_range(0, 9));
                default: k = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
            endcase
            len = $urandom_range(1, 2 * DEB + 3);
            if ($urandom_range(0, 60) == 0) begin
                cyc(k, 1'b0, 1'b0);
            end else begin
                hold(k, ($urandom_range(0, 7) == 0), len);
            end
        end
        hold('0, 1'b0, 10);

        repeat (2) @(negedge clk);
        done = 1;
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/num_encoder10.md
NUM_ENCODER10 -- requirements
Module: num_encoder10

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, the number of consecutive stable clock samples that qualify a press or a release (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, the debounce counter width; CNT_W SHALL satisfy 2^CNT_W > DEB_CYCLES.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port key_n  input  10  raw asynchronous keys 0-9; 0 means pressed.
REQ-006 SHALL have port LE  input  1  latch enable; 1 freezes D and err.
REQ-007 SHALL have port D  output  4  BCD code of the accepted key; 4'b1111 means no code.
REQ-008 SHALL have port valid  output  1  level; high while an accepted key is held, including release debounce.
REQ-009 SHALL have port strobe  output  1  one-cycle pulse when a press is accepted.
REQ-010 SHALL have port err  output  1  more than one key was pressed in the accepted vector.

Function
REQ-011 SHALL pass ~key_n through a two-flop synchronizer; all logic below uses the synchronized active-high vector kv.
REQ-012 SHALL implement the FSM states IDLE, DEB, HELD and REL, each registered.
REQ-013 IDLE: if kv != 0, go to DEB with cand=kv and cnt=0; otherwise stay in IDLE.
REQ-014 DEB, kv == 0: return to IDLE with no output change.
REQ-015 DEB, kv != cand and kv != 0: set cand=kv and cnt=0; remain in DEB.
REQ-016 DEB, kv == cand and cnt < DEB_CYCLES-1: increment cnt.
REQ-017 DEB, kv == cand and cnt == DEB_CYCLES-1: go to HELD and accept cand.
REQ-018 Accepting cand with LE=0 SHALL, at the same edge:
  - load D with the index of the highest set bit of cand;
  - load err = (popcount(cand) > 1);
  - set valid=1;
  - pulse strobe for exactly one cycle.
REQ-019 Accepting cand with LE=1 SHALL set valid=1, leave D and err unchanged and suppress strobe.
REQ-020 HELD: changes of kv while kv != 0 are ignored (no re-encode, no strobe); kv == 0 moves to REL with cnt=0.
REQ-021 REL: kv != 0 returns to HELD with no strobe.
REQ-022 REL: kv == 0 increments cnt; at cnt == DEB_CYCLES-1, go to IDLE and clear valid; D and err hold their last values.
REQ-023 LE SHALL freeze D and err in every state.
REQ-024 Press latency SHALL be exactly DEB_CYCLES+3 rising edges from the first edge sampling a stable pressed key to strobe high; the strobe cycle is the cycle after that edge.
REQ-025 No combinational path SHALL exist from any input to any output.

Reset
REQ-026 On rst_n=0, immediately and asynchronously:
  - state=IDLE, cnt=0, cand=0, synchronizer flops=0;
  - D=4'b1111, valid=0, strobe=0, err=0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no strobe.
REQ-028 After rst_n deasserts, a key already held SHALL be treated as a new press, with full latency.

Verification (DEB_CYCLES=4)
REQ-029 Single press: key 7 held stable, LE=0 -> strobe for one cycle after edge 7, D=4'b0111, valid=1, err=0.
REQ-030 Bounce: key 3 toggles every 2 cycles for 10 cycles, then stays stable -> no strobe during bouncing; one strobe 7 edges after it stabilises; D=4'b0011.
REQ-031 Multi-key: keys 2 and 9 pressed together -> D=4'b1001, err=1, one strobe.
REQ-032 Release glitch: while key 5 is held, it is released for 2 cycles, then re-pressed -> valid stays 1 and no second strobe; a full release of at least 4 cycles clears valid after 4 zero samples.
REQ-033 LE hold: D=4'b0001, then with LE=1 key 8 is pressed -> D stays 4'b0001, valid=1, strobe never pulses.
REQ-034 Reset mid-DEB: rst_n pulsed low at edge 5 of a press -> outputs return to reset values at once; no strobe; the still-held key is accepted 7 edges after release of reset.
